// File: rtl/sa_operand_framer.sv
// rtl/sa_operand_framer.sv - joins A/B operand streams into tagged beats for the systolic-array wrapper
// Optional feature macro: SA_FRAMER_STALL_CNT_EN (backpressure stall counter on stall_cnt_o)
module sa_operand_framer #(
  parameter int DATA_WIDTH     = 1024,
  parameter int ARITH_IN_WIDTH = 4,
  parameter int N              = 32,
  parameter int M              = 31,
  parameter int K_WIDTH        = 16,
  parameter int NB_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [K_WIDTH-1:0]          cfg_k_i,
  input  logic [NB_WIDTH-1:0]         cfg_nblocks_i,
  output logic                        busy_o,
  output logic                        done_o,
  input  logic                        a_valid_i,
  output logic                        a_ready_o,
  input  logic [N*ARITH_IN_WIDTH-1:0] a_data_i,
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  input  logic [M*ARITH_IN_WIDTH-1:0] b_data_i,
  output logic                        rts_o,
  input  logic                        rtr_i,
  output logic                        sow_o,
  output logic                        eow_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic [31:0]                 stall_cnt_o
);

  localparam int AW = N * ARITH_IN_WIDTH;
  localparam int BW = M * ARITH_IN_WIDTH;

  if ((N + M) * ARITH_IN_WIDTH > DATA_WIDTH - 2) begin : g_width_check
    $fatal(1, "sa_operand_framer: A+B operands do not fit beside the SOB/EOB bits");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [K_WIDTH-1:0]    r_cfg_k;
  logic [K_WIDTH-1:0]    r_k_cnt;
  logic [NB_WIDTH-1:0]   r_cfg_nb;
  logic [NB_WIDTH-1:0]   r_blk_cnt;
  logic                  r_rts;
  logic                  r_sow;
  logic                  r_eow;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  w_cfg_ok;
  logic                  w_start_ok;
  logic                  w_room;
  logic                  w_load;
  logic                  w_sob;
  logic                  w_eob;
  logic                  w_eow;
  logic                  w_done_nxt;
  logic [DATA_WIDTH-1:0] w_beat;

  assign w_cfg_ok   = (cfg_k_i != '0) && (cfg_nblocks_i != '0);
  assign w_start_ok = (r_state == S_IDLE) && start_i && w_cfg_ok;
  // The output register can take a new beat when empty or when its beat leaves this cycle.
  assign w_room     = ~r_rts | rtr_i;
  assign w_sob      = (r_k_cnt == '0);
  assign w_eob      = (r_k_cnt == r_cfg_k - K_WIDTH'(1));
  assign w_eow      = w_eob && (r_blk_cnt == r_cfg_nb - NB_WIDTH'(1));

  assign busy_o = (r_state != S_IDLE);
  assign done_o = r_done;
  assign rts_o  = r_rts;
  assign sow_o  = r_sow;
  assign eow_o  = r_eow;
  assign data_o = r_data;

  // Pack A, B and the block flags into one bus beat; unused bits stay zero.
  always_comb begin
    w_beat                  = '0;
    w_beat[AW-1:0]          = a_data_i;
    w_beat[AW+BW-1:AW]      = b_data_i;
    w_beat[DATA_WIDTH-2]    = w_sob;
    w_beat[DATA_WIDTH-1]    = w_eob;
  end

  // Next-state, stream readies and load strobe; A and B are only ever taken together.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    a_ready_o   = 1'b0;
    b_ready_o   = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (w_cfg_ok) w_state_nxt = S_RUN;
          else          w_done_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        a_ready_o = b_valid_i & w_room;
        b_ready_o = a_valid_i & w_room;
        w_load    = a_valid_i & b_valid_i & w_room;
        if (w_load && w_eow) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (r_rts && rtr_i) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Job configuration and beat/block position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_k   <= '0;
      r_cfg_nb  <= '0;
      r_k_cnt   <= '0;
      r_blk_cnt <= '0;
    end else if (w_start_ok) begin
      r_cfg_k   <= cfg_k_i;
      r_cfg_nb  <= cfg_nblocks_i;
      r_k_cnt   <= '0;
      r_blk_cnt <= '0;
    end else if (w_load) begin
      if (w_eob) begin
        r_k_cnt   <= '0;
        r_blk_cnt <= r_blk_cnt + NB_WIDTH'(1);
      end else begin
        r_k_cnt   <= r_k_cnt + K_WIDTH'(1);
      end
    end
  end

  // Output register: loads a beat, holds it under backpressure, empties once accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rts  <= 1'b0;
      r_sow  <= 1'b0;
      r_eow  <= 1'b0;
      r_data <= '0;
    end else if (w_load) begin
      r_rts  <= 1'b1;
      r_sow  <= w_sob && (r_blk_cnt == '0);
      r_eow  <= w_eow;
      r_data <= w_beat;
    end else if (r_rts && rtr_i) begin
      r_rts  <= 1'b0;
    end
  end

  // Job-end pulse, also raised for a start with an empty configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= w_done_nxt;
  end

`ifdef SA_FRAMER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles a beat waits on the wrapper.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_stall_cnt <= '0;
    else if (w_start_ok)                       r_stall_cnt <= '0;
    else if (r_rts && !rtr_i && (r_stall_cnt != 32'hFFFF_FFFF))
                                               r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule
